// File: rtl/core_if_id.sv
// Two-entry instruction buffer between fetch and core_id. Absorbs decode
// holds, discards in-flight pairs on flush and presents a NOP when empty.
module core_if_id #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic [31:0] inst_addr_in,
  input  logic        inst_valid_in,
  output logic        inst_ready_out,
  input  logic        hold_in,
  input  logic        flush_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out,
  output logic        inst_valid_out,
  output logic [1:0]  count_out
);

  logic [31:0] inst_mem [2];
  logic [31:0] addr_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Ready depends only on registered occupancy and reset, never on hold/flush.
  assign inst_ready_out = rst & ~full;
  assign inst_valid_out = ~empty;

  assign push = inst_valid_in & inst_ready_out;
  assign pop  = inst_valid_out & ~hold_in;

  assign inst_out      = empty ? NOP_INST   : inst_mem[rd_ptr];
  assign inst_addr_out = empty ? RESET_ADDR : addr_mem[rd_ptr];
  assign count_out     = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry payload needs no reset: it is only observable while count says valid.
  always_ff @(posedge clk) begin
    if (push && !flush_in) begin
      inst_mem[wr_ptr] <= inst_in;
      addr_mem[wr_ptr] <= inst_addr_in;
    end
  end

endmodule
